// File: rtl/r16_rom_read_ctrl_if.sv
// -----------------------------------------------------------------------------
// r16_rom_read_ctrl_if
// Groups the run-control and ROM-read signals of the radix-16 twiddle-factor
// ROM read sequencer.
//
//   Upstream (master drives, slave samples):
//     start       single-cycle run request
//     num_groups  ROM reads per stage
//     num_stages  stages per run
//     hold        downstream backpressure, suppresses new issues
//   Sequencer (slave drives, master samples):
//     rom_en      ROM read enable
//     rom_addr    strided ROM read address
//     busy        run in progress
//     tf_valid    ROM data at pipeline output is valid
//     tf_last     valid word is the last group of its stage
//     tf_stage    stage index of the valid word
//     done        single-cycle run-complete pulse
// -----------------------------------------------------------------------------
interface r16_rom_read_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 10,
  parameter int STG_WIDTH  = 3
);
  logic                  start;
  logic [CNT_WIDTH-1:0]  num_groups;
  logic [STG_WIDTH-1:0]  num_stages;
  logic                  hold;
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  busy;
  logic                  tf_valid;
  logic                  tf_last;
  logic [STG_WIDTH-1:0]  tf_stage;
  logic                  done;

  modport master (
    output start, num_groups, num_stages, hold,
    input  rom_en, rom_addr, busy, tf_valid, tf_last, tf_stage, done
  );

  modport slave (
    input  start, num_groups, num_stages, hold,
    output rom_en, rom_addr, busy, tf_valid, tf_last, tf_stage, done
  );
endinterface

// File: rtl/r16_rom_read_ctrl.sv
// -----------------------------------------------------------------------------
// r16_rom_read_ctrl
// Sequencer for the radix-16 twiddle-factor ROM read path. Issues one ROM read
// per group per FFT stage with address (grp << 4*stg) mod 2^ADDR_WIDTH, and
// carries a {valid, last, stage} tag through a LAT-deep shift register so the
// tag leaves the chain in the same cycle as the matching ROM data word.
//
// Ports:
//   clk     clock
//   rst_n   asynchronous active-low reset
//   io_bus  r16_rom_read_ctrl_if.slave (start/num_groups/num_stages/hold in,
//           rom_en/rom_addr/busy/tf_valid/tf_last/tf_stage/done out)
//
// Build option:
//   R16_STAGE_GAP_EN  when defined, a one-cycle GAP bubble (rom_en=0) is
//                     inserted after the last issue of every non-final stage.
// -----------------------------------------------------------------------------
module r16_rom_read_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 10,
  parameter int STG_WIDTH  = 3,
  parameter int LAT        = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  r16_rom_read_ctrl_if.slave   io_bus
);

  typedef struct packed {
    logic                 valid;
    logic                 last;
    logic [STG_WIDTH-1:0] stage;
  } tag_t;

`ifdef R16_STAGE_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
`endif

  state_t                r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_num_groups, r_grp_cnt, w_grp_nxt;
  logic [STG_WIDTH-1:0]  r_num_stages, r_stg_cnt, w_stg_nxt;
  logic [ADDR_WIDTH-1:0] r_rom_addr, w_addr_nxt;
  logic                  r_done_empty;
  tag_t                  r_tag [LAT];

  logic w_accept, w_empty_run, w_last_grp, w_final, w_tags_empty;
  logic w_rom_en, w_busy, w_done;

  // A start is only honoured in IDLE; while busy it is dropped.
  assign w_accept    = (r_state == IDLE) && io_bus.start;
  assign w_empty_run = (io_bus.num_groups == '0) || (io_bus.num_stages == '0);
  assign w_last_grp  = (r_grp_cnt == r_num_groups - CNT_WIDTH'(1));
  assign w_final     = w_last_grp && (r_stg_cnt == r_num_stages - STG_WIDTH'(1));

  always_comb begin
    w_tags_empty = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      if (r_tag[i].valid) w_tags_empty = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: state is written with <= so every flop samples pre-edge values;
  // blocking assignments here would make ordering between blocks matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !w_empty_run) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_rom_en && w_last_grp) begin
          if (w_final) w_state_nxt = DRAIN;
`ifdef R16_STAGE_GAP_EN
          else         w_state_nxt = GAP;
`endif
        end
      end
`ifdef R16_STAGE_GAP_EN
      GAP:     w_state_nxt = RUN;
`endif
      DRAIN: begin
        if (w_tags_empty) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // rom_en reacts to hold in the same cycle so a held cycle issues nothing.
  // done for a real run fires in the first DRAIN cycle with an empty chain,
  // i.e. the cycle after the final tf_valid, while busy is still high.
  always_comb begin
    w_rom_en = (r_state == RUN) && !io_bus.hold;
    w_busy   = (r_state != IDLE);
    w_done   = r_done_empty || ((r_state == DRAIN) && w_tags_empty);
  end

  // ---------------------------------------------------------------------------
  // Group/stage counters and the registered address of the next issue
  // ---------------------------------------------------------------------------
  always_comb begin
    w_grp_nxt = r_grp_cnt;
    w_stg_nxt = r_stg_cnt;
    if (w_accept) begin
      w_grp_nxt = '0;
      w_stg_nxt = '0;
    end else if (w_rom_en) begin
      if (w_last_grp) begin
        w_grp_nxt = '0;
        w_stg_nxt = r_stg_cnt + STG_WIDTH'(1);
      end else begin
        w_grp_nxt = r_grp_cnt + CNT_WIDTH'(1);
      end
    end
    // Truncating before the shift gives the same result as shifting the full
    // count and wrapping modulo 2^ADDR_WIDTH.
    w_addr_nxt = ADDR_WIDTH'(w_grp_nxt) << {w_stg_nxt, 2'b00};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_groups <= '0;
      r_num_stages <= '0;
      r_grp_cnt    <= '0;
      r_stg_cnt    <= '0;
      r_rom_addr   <= '0;
      r_done_empty <= 1'b0;
    end else begin
      if (w_accept) begin
        r_num_groups <= io_bus.num_groups;
        r_num_stages <= io_bus.num_stages;
      end
      r_grp_cnt    <= w_grp_nxt;
      r_stg_cnt    <= w_stg_nxt;
      r_rom_addr   <= w_addr_nxt;
      r_done_empty <= w_accept && w_empty_run;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag shift register, free-running like the ROM delay chain it shadows
  // ---------------------------------------------------------------------------
  // NOTE: this array is reset on purpose: a stale valid bit after reset would
  // produce a phantom tf_valid and hold DRAIN open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_rom_en, last: w_rom_en && w_last_grp, stage: r_stg_cnt};
      for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign io_bus.rom_en   = w_rom_en;
  assign io_bus.rom_addr = r_rom_addr;
  assign io_bus.busy     = w_busy;
  assign io_bus.done     = w_done;
  assign io_bus.tf_valid = r_tag[LAT-1].valid;
  assign io_bus.tf_last  = r_tag[LAT-1].last;
  assign io_bus.tf_stage = r_tag[LAT-1].stage;

endmodule

// File: tb/tb_r16_rom_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_r16_rom_read_ctrl
// Scoreboard bench: each directed run pushes its expected rom_en, tf_valid and
// done events (cycle relative to the start edge plus payload) into queues; a
// negedge monitor pops and compares whenever the DUT presents one of them.
// -----------------------------------------------------------------------------
module tb_r16_rom_read_ctrl;
  localparam int LAT = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  r16_rom_read_ctrl_if bus ();

  r16_rom_read_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  typedef struct { int cyc; int addr; }           addr_ev_t;
  typedef struct { int cyc; int last; int stage; } tf_ev_t;
  typedef struct { int cyc; int busy; }           done_ev_t;

  addr_ev_t q_addr[$];
  tf_ev_t   q_tf[$];
  done_ev_t q_done[$];
  int       addr_tab[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every DUT event against the head of its queue.
  always @(negedge clk) begin
    int rel;
    addr_ev_t ea;
    tf_ev_t   et;
    done_ev_t ed;
    rel = cyc - t0;
    if (bus.rom_en === 1'b1) begin
      check("rom_en_expected", int'(q_addr.size() != 0), 1);
      if (q_addr.size() != 0) begin
        ea = q_addr.pop_front();
        check("rom_en_cycle", rel, ea.cyc);
        check("rom_addr", int'(bus.rom_addr), ea.addr);
      end
    end
    if (bus.tf_valid === 1'b1) begin
      check("tf_valid_expected", int'(q_tf.size() != 0), 1);
      if (q_tf.size() != 0) begin
        et = q_tf.pop_front();
        check("tf_valid_cycle", rel, et.cyc);
        check("tf_last", int'(bus.tf_last), et.last);
        check("tf_stage", int'(bus.tf_stage), et.stage);
      end
    end
    if (bus.done === 1'b1) begin
      check("done_expected", int'(q_done.size() != 0), 1);
      if (q_done.size() != 0) begin
        ed = q_done.pop_front();
        check("done_cycle", rel, ed.cyc);
        check("busy_at_done", int'(bus.busy), ed.busy);
      end
    end
  end

  // Expected events from the run parameters and the hand-computed address
  // table; events at or after cutoff are not expected (reset case).
  task automatic gen(input int ng, input int ns, input logic [63:0] hold_mask,
                     input int cutoff);
    int c;
    int idx;
    c   = 1;
    idx = 0;
    if (ng == 0 || ns == 0) begin
      q_done.push_back(done_ev_t'{1, 0});
      return;
    end
    for (int s = 0; s < ns; s++) begin
      for (int g = 0; g < ng; g++) begin
        while (c < 64 && hold_mask[c]) c++;
        if (c < cutoff)       q_addr.push_back(addr_ev_t'{c, addr_tab[idx]});
        if (c + LAT < cutoff) q_tf.push_back(tf_ev_t'{c + LAT, int'(g == ng - 1), s});
        idx++;
        c++;
      end
`ifdef R16_STAGE_GAP_EN
      if (s != ns - 1) c++;
`endif
    end
    if (c + LAT < cutoff) q_done.push_back(done_ev_t'{c + LAT, 1});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rom_en"},   int'(bus.rom_en),   0);
    check({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    check({tag, "_busy"},     int'(bus.busy),     0);
    check({tag, "_tf_valid"}, int'(bus.tf_valid), 0);
    check({tag, "_tf_last"},  int'(bus.tf_last),  0);
    check({tag, "_tf_stage"}, int'(bus.tf_stage), 0);
    check({tag, "_done"},     int'(bus.done),     0);
  endtask

  // Issue start, then for n_cycles drive hold, scramble the run inputs
  // (must be ignored), optionally re-pulse start or assert reset.
  task automatic run_case(input int ng, input int ns, input logic [63:0] hold_mask,
                          input int restart_at, input int reset_at, input int n_cycles);
    int rel;
    @(posedge clk); #1;
    bus.num_groups = 10'(ng);
    bus.num_stages = 3'(ns);
    bus.hold       = 1'b0;
    bus.start      = 1'b1;
    t0 = cyc;
    for (int k = 0; k < n_cycles; k++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      bus.start      = (rel == restart_at);
      bus.num_groups = 10'd7;
      bus.num_stages = 3'd5;
      bus.hold       = (rel < 64) ? hold_mask[rel] : 1'b0;
      if (rel == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
      end else begin
        rst_n = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    check("addr_events_left", q_addr.size(), 0);
    check("tf_events_left",   q_tf.size(),   0);
    check("done_events_left", q_done.size(), 0);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.hold       = 1'b0;
    bus.num_groups = '0;
    bus.num_stages = '0;
    #2;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 4 groups x 2 stages, no backpressure
    addr_tab = '{0, 1, 2, 3, 0, 16, 32, 48};
    gen(4, 2, 64'h0, 1000);
    run_case(4, 2, 64'h0, -1, -1, 25);

    // same run, hold high in cycles 2-3
    gen(4, 2, 64'hC, 1000);
    run_case(4, 2, 64'hC, -1, -1, 27);

    // 8 groups x 3 stages: stage 1 wraps mod 64, stage 2 is all zero
    addr_tab = '{0, 1, 2, 3, 4, 5, 6, 7,
                 0, 16, 32, 48, 0, 16, 32, 48,
                 0, 0, 0, 0, 0, 0, 0, 0};
    gen(8, 3, 64'h0, 1000);
    run_case(8, 3, 64'h0, -1, -1, 40);

    // empty runs: zero groups, then zero stages
    gen(0, 2, 64'h0, 1000);
    run_case(0, 2, 64'h0, -1, -1, 5);
    gen(3, 0, 64'h0, 1000);
    run_case(3, 0, 64'h0, -1, -1, 5);

    // start re-pulsed in cycle 3 while busy: sequence unchanged
    addr_tab = '{0, 1, 2, 3, 0, 16, 32, 48};
    gen(4, 2, 64'h0, 1000);
    run_case(4, 2, 64'h0, 3, -1, 25);

    // reset in cycle 5 of an 8x2 run: only cycles 1-4 issue, nothing after
    addr_tab = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 16, 32, 48, 0, 16, 32, 48};
    gen(8, 2, 64'h0, 5);
    run_case(8, 2, 64'h0, -1, 5, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
